// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared owner enum and width constants for mem_port_arbiter
package mem_arb_pkg;
  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;
  localparam int LANES_DEF = DW_DEF / 8;
  typedef enum logic [1:0] {OWN_IDLE, OWN_I, OWN_D} own_t;
  function automatic int lanes(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory port bundle of mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int AW = mem_arb_pkg::AW_DEF,
  parameter int DW = mem_arb_pkg::DW_DEF
) ();
  logic            i_req;
  logic [AW-1:0]   i_addr;
  logic            i_gnt;
  logic            i_rvalid;
  logic [DW-1:0]   i_rdata;
  logic            d_req;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_we;
  logic            d_gnt;
  logic            d_rvalid;
  logic [DW-1:0]   d_rdata;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_we;
  logic [DW-1:0]   m_rdata;
  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_wdata, d_we, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_addr, m_wdata, m_we
  );
  modport master (
    output i_req, i_addr, d_req, d_addr, d_wdata, d_we, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_addr, m_wdata, m_we
  );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: one-hot {d,i} grant; data priority with starvation guard, or round-robin with MEM_ARB_RR_EN
module mem_arb_pick #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_req,
  input  logic       d_req,
  output logic [1:0] gnt
);
  logic i_win;
`ifdef MEM_ARB_RR_EN
  logic last_d;
  always_comb begin
    i_win = i_req & (~d_req | last_d);
    gnt = reset ? 2'b00 : {d_req & ~i_win, i_win};
  end
  always_ff @(posedge clk) begin
    if (reset) last_d <= 1'b1;
    else if (|gnt) last_d <= gnt[1];
  end
`else
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt;
  always_comb begin
    i_win = i_req & (~d_req | (starve_cnt == CW'(STARVE_LIMIT)));
    gnt = reset ? 2'b00 : {d_req & ~i_win, i_win};
  end
  always_ff @(posedge clk) begin
    if (reset || !i_req || gnt[0]) starve_cnt <= '0;
    else if (starve_cnt != CW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
  end
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 1-cycle-read memory port between fetch and data; MEM_ARB_RR_EN selects round-robin
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  localparam int NB = lanes(DW);
  logic [1:0]    gnt;
  own_t          own_q, own_d;
  logic          st_q;
  logic [AW-1:0] addr_q;
  mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk   (clk),
    .reset (reset),
    .i_req (bus.i_req),
    .d_req (bus.d_req),
    .gnt   (gnt)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      own_q  <= OWN_IDLE;
      st_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      own_q  <= own_d;
      st_q   <= |bus.m_we;
      addr_q <= bus.m_addr;
    end
  end
  // reset gates the response so an in-flight read is dropped
  always_comb begin
    own_d = gnt[0] ? OWN_I : gnt[1] ? OWN_D : OWN_IDLE;
    bus.i_gnt = gnt[0];
    bus.d_gnt = gnt[1];
    bus.m_addr = reset ? '0 : gnt[0] ? bus.i_addr : gnt[1] ? bus.d_addr : addr_q;
    bus.m_wdata = gnt[1] ? bus.d_wdata : '0;
    bus.m_we = gnt[1] ? bus.d_we : NB'(0);
    bus.i_rvalid = ~reset & (own_q == OWN_I);
    bus.i_rdata = bus.i_rvalid ? bus.m_rdata : '0;
    bus.d_rvalid = ~reset & (own_q == OWN_D);
    bus.d_rdata = (bus.d_rvalid & ~st_q) ? bus.m_rdata : '0;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified, byte-write-enabled memory port between two requesters: the instruction-fetch path and the data load/store path.
- Decides which requester issues each cycle and drives the memory address, write data and write enables.
- Tracks the single outstanding 1-cycle read response and routes it back to the requester that issued it.
- Sits between the core's iaddr/idata and daddr/drdata/dwdata/dwe ports and a single-ported memory model.

Parameters:
- AW, 32, address width.
- DW, 32, data width; DW/8 byte lanes.
- STARVE_LIMIT, 4, consecutive cycles fetch may lose before it is forced to win.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held high with stable i_addr until i_gnt.
- i_addr  in  AW  fetch word address.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  i_rdata valid; one cycle after i_gnt.
- i_rdata  out  DW  fetched instruction.
- d_req  in  1  data request; held with stable d_addr/d_wdata/d_we until d_gnt.
- d_addr  in  AW  data byte address.
- d_wdata  in  DW  store data, already lane-aligned.
- d_we  in  DW/8  byte write enables; 0 means load.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  completion pulse, one cycle after d_gnt, for loads and stores.
- d_rdata  out  DW  load data; 0 on store completion.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_we  out  DW/8  memory byte write enables.
- m_rdata  in  DW  memory read data; valid the cycle after the address is presented.

Behaviour:
- Reset: all outputs 0 (i_gnt, d_gnt, i_rvalid, d_rvalid, m_we = 0; m_addr, m_wdata, i_rdata, d_rdata = 0).
  - Reset also clears the owner state to IDLE and the starvation counter to 0.
- Reset mid-operation: any outstanding response is dropped; no rvalid pulse follows.
- Grant path is combinational in the request cycle.
  - At most one of i_gnt/d_gnt is high per cycle.
  - The grant is never high while reset is asserted.
  - m_addr, m_wdata and m_we reflect the winner in that same cycle.
  - With no winner: m_we = 0 and m_addr holds its last value.
- m_wdata and m_we are driven only for a data grant; a fetch grant forces m_we = 0.
- Arbitration (default):
  - Data wins over fetch when both request.
  - Exception: when starve_cnt == STARVE_LIMIT, fetch wins.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each cycle i_req is high and not granted.
  - Clears to 0 on i_gnt or when i_req is low.
- Owner FSM, registered:
  - States: IDLE, I_RESP, D_RESP.
  - Next state = I_RESP on i_gnt, D_RESP on d_gnt, otherwise IDLE.
  - In I_RESP: i_rvalid = 1 and i_rdata = m_rdata.
  - In D_RESP: d_rvalid = 1; d_rdata = m_rdata if the latched d_we was 0, else 0.
- Throughput: fully pipelined. A new grant may issue in the same cycle a response is returned, giving back-to-back 1 request/cycle.
- Latency: grant in cycle N, rvalid in cycle N+1.
- Alignment: d_addr is passed through unmodified; lane shifting and sign extension stay in the core.
- A request that drops without a grant is simply ignored; there is no error.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: fixed priority and starve_cnt are replaced by round-robin.
  - A 1-bit last-winner register is used; on contention the requester that did not win last wins.
  - The register resets to "data won last", so fetch wins the first contention.
- Undefined: data-priority arbitration with the STARVE_LIMIT guard as above.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the owner enum {OWN_IDLE, OWN_I, OWN_D};
  - AW/DW default constants;
  - the byte-lane count constant.
- One natural sub-module: mem_arb_pick.
  - 2-way pick logic: fixed priority + starve counter, or round-robin under MEM_ARB_RR_EN.
  - Outputs a one-hot grant.
- The owner FSM and response muxing stay in the top module.

Test Plan:
- Reset held 3 cycles with i_req=d_req=1 -> both grants and both rvalids stay 0, m_we=0; first grant appears the cycle after reset drops.
- Fetch only: i_req=1, i_addr=0x0,0x4,0x8 on consecutive cycles -> i_gnt=1 every cycle; i_rvalid in cycles 1..3 with memory words 0,1,2; d_rvalid=0.
- Store then load: d_we=4'b0010, d_addr=0x101, d_wdata=0x0000AB00, next d_we=0, d_addr=0x100.
  - The store sets m_we=4'b0010 in its grant cycle.
  - The load's d_rdata has byte1 = 0xAB; store completion gives d_rdata=0.
- Contention, default build: i_req=d_req=1 held for 8 cycles.
  - d_gnt cycles 0-3; i_gnt at cycle 4 (starve_cnt=4); then d_gnt resumes.
  - No cycle has both grants.
- Contention with MEM_ARB_RR_EN: same stimulus -> grants alternate i,d,i,d starting with fetch.
- Reset asserted the cycle after a d_gnt load -> no d_rvalid; FSM in IDLE; starve_cnt=0.
